// File: rtl/alu_ctrl_pipe.sv
// Registered ALU-control stage between ID and EX: decodes opcode/funct into an
// ALU function code, holds it behind a valid/ready handshake, stretches MUL ops.
module alu_ctrl_pipe #(
    parameter int OP_W    = 3,
    parameter int FUNCT_W = 3,
    parameter int ALUF_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUF_W-1:0]  alu_funct,
    output logic               illegal,
    output logic               busy,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam int CW         = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam int CNT_INIT_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam logic [CW-1:0] CNT_INIT = CW'(CNT_INIT_I);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LB    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);

    localparam logic [ALUF_W-1:0] F_ADD    = ALUF_W'(0);
    localparam logic [ALUF_W-1:0] F_ILL    = ALUF_W'(1);
    localparam logic [ALUF_W-1:0] F_SUB    = ALUF_W'(2);
    localparam logic [ALUF_W-1:0] MUL_CODE = {1'b1, {(ALUF_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        MULTI = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ALUF_W-1:0]  funct_q, funct_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;

    logic [ALUF_W-1:0]  decFunct;
    logic               decIllegal;
    logic               decMul;
    logic               accept;

    always_comb begin
        decFunct   = F_ILL;
        decIllegal = 1'b1;
        decMul     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                decIllegal = 1'b0;
                if (funct_in == '1) begin
                    decMul   = 1'b1;
                    decFunct = MUL_CODE;
                end else begin
                    decFunct = {{(ALUF_W-FUNCT_W){1'b0}}, funct_in};
                end
            end
            OP_ADDI, OP_LB, OP_SB: begin
                decIllegal = 1'b0;
                decFunct   = F_ADD;
            end
            OP_BEQ: begin
                decIllegal = 1'b0;
                decFunct   = F_SUB;
            end
            default: ;
        endcase
    end

    // Flush blocks acceptance and collapses to IDLE, but the captured code survives.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct_d   = funct_q;
        illegal_d = illegal_q;
        icnt_d    = icnt_q;
        in_ready  = !flush && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
        accept    = in_valid && in_ready;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        funct_d   = decFunct;
                        illegal_d = decIllegal;
                        if (decIllegal && (icnt_q != '1)) begin
                            icnt_d = icnt_q + CNT_W'(1);
                        end
                        if (decMul && (MUL_LAT > 1)) begin
                            state_d = MULTI;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if ((state_q == HOLD) && out_ready) begin
                        state_d = IDLE;
                    end
                end
                MULTI: begin
                    if (cnt_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
            icnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
            icnt_q    <= icnt_d;
        end
    end

    assign out_valid   = (state_q == HOLD);
    assign busy        = (state_q == MULTI);
    assign alu_funct   = funct_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = icnt_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: a cycle model of the handshake and decode
// table is compared every cycle, plus literal expectations for each scenario.
module tb_alu_ctrl_pipe;

    localparam int MUL_LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] opcode = 3'd0;
    logic [2:0] funct_in = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_funct;
    logic       illegal;
    logic       busy;
    logic [7:0] illegal_cnt;

    int errors = 0;
    int checks = 0;

    alu_ctrl_pipe #(
        .OP_W(3), .FUNCT_W(3), .ALUF_W(4), .MUL_LAT(MUL_LAT), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct_in(funct_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_funct(alu_funct), .illegal(illegal),
        .busy(busy), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and return just after the edge that samples them.
    task automatic applyStimulus(input logic v, input logic [2:0] op,
                                 input logic [2:0] fn, input logic ordy,
                                 input logic fl);
        in_valid  = v;
        opcode    = op;
        funct_in  = fn;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Model: "holding" means a result is presented; "pending" counts busy cycles left.
    bit         mHold = 1'b0;
    int         mPend = 0;
    logic [3:0] mFunct = 4'd0;
    bit         mIll = 1'b0;
    int         mCnt = 0;
    bit         checking = 1'b0;

    function automatic bit modelReady();
        return !flush && (mPend == 0) && (!mHold || out_ready);
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        acc = in_valid && modelReady();
        if (rst) begin
            mHold = 0; mPend = 0; mFunct = 4'd0; mIll = 0; mCnt = 0;
            checking = 1'b1;
        end else if (flush) begin
            mHold = 0; mPend = 0;
        end else if (mPend > 0) begin
            mPend = mPend - 1;
            if (mPend == 0) mHold = 1;
        end else if (acc) begin
            bit isMul;
            isMul = 0;
            mIll  = 0;
            if (opcode == 0) begin
                if (funct_in == 7) begin mFunct = 4'd8; isMul = 1; end
                else mFunct = {1'b0, funct_in};
            end else if (opcode == 1 || opcode == 2 || opcode == 3) begin
                mFunct = 4'd0;
            end else if (opcode == 4) begin
                mFunct = 4'd2;
            end else begin
                mFunct = 4'd1;
                mIll   = 1;
                if (mCnt < 255) mCnt = mCnt + 1;
            end
            if (isMul && MUL_LAT > 1) begin
                mPend = MUL_LAT - 1;
                mHold = 0;
            end else begin
                mHold = 1;
            end
        end else if (mHold && out_ready) begin
            mHold = 0;
        end
    end

    always @(negedge clk) begin : compare
        if (checking) begin
            checkOutput("out_valid",   32'(out_valid),   32'(mHold));
            checkOutput("busy",        32'(busy),        32'(mPend > 0));
            checkOutput("in_ready",    32'(in_ready),    32'(modelReady()));
            checkOutput("alu_funct",   32'(alu_funct),   32'(mFunct));
            checkOutput("illegal",     32'(illegal),     32'(mIll));
            checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(mCnt));
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_alu_funct", 32'(alu_funct), 32'd0);
        checkOutput("reset_cnt", 32'(illegal_cnt), 32'd0);

        // BEQ decodes to SUB with one cycle of latency
        applyStimulus(1, 3'd4, 0, 1, 0);
        checkOutput("beq_valid", 32'(out_valid), 32'd1);
        checkOutput("beq_funct", 32'(alu_funct), 32'h2);
        checkOutput("beq_illegal", 32'(illegal), 32'd0);

        // MUL: busy for three cycles, ops offered meanwhile are ignored
        applyStimulus(1, 3'd0, 3'd7, 1, 0);
        checkOutput("mul_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mul_busy", 32'(busy), 32'd1);
            checkOutput("mul_no_valid", 32'(out_valid), 32'd0);
            applyStimulus(1, 3'd1, 0, 1, 0);
        end
        checkOutput("mul_valid", 32'(out_valid), 32'd1);
        checkOutput("mul_funct", 32'(alu_funct), 32'h8);
        checkOutput("mul_busy_done", 32'(busy), 32'd0);

        // ADDI held under backpressure while BEQ waits
        applyStimulus(1, 3'd1, 0, 1, 0);
        checkOutput("addi_funct", 32'(alu_funct), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 3'd4, 0, 0, 0);
            checkOutput("hold_funct", 32'(alu_funct), 32'h0);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
        end
        applyStimulus(1, 3'd4, 0, 1, 0);
        checkOutput("release_funct", 32'(alu_funct), 32'h2);

        // R-type non-MUL funct is zero-extended
        applyStimulus(1, 3'd0, 3'd5, 1, 0);
        checkOutput("rtype_funct", 32'(alu_funct), 32'h5);

        // Illegal stream, back-to-back, counter saturates
        for (int i = 0; i < 260; i++) applyStimulus(1, 3'd7, 0, 1, 0);
        checkOutput("ill_flag", 32'(illegal), 32'd1);
        checkOutput("ill_funct", 32'(alu_funct), 32'h1);
        checkOutput("ill_sat", 32'(illegal_cnt), 32'd255);

        // Flush during MULTI: no stale MUL result, code retained
        applyStimulus(1, 3'd0, 3'd7, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 3'd4, 0, 1, 1);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_funct_kept", 32'(alu_funct), 32'h8);
        checkOutput("flush_cnt_kept", 32'(illegal_cnt), 32'd255);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput("flush_no_stale", 32'(out_valid), 32'd0);
        end

        // Reset while HOLD with a new op offered
        applyStimulus(1, 3'd6, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(1, 3'd4, 0, 1, 0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_funct", 32'(alu_funct), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_cnt", 32'(illegal_cnt), 32'd0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
